// File: rtl/step_fsm_pkg.sv
// Shared constants and the step/next-state rule for step_fsm.
// The rule is kept here so that clamp and exact behaviour live in one place.
package step_fsm_pkg;

    localparam logic MODE_CLAMP = 1'b0;
    localparam logic MODE_EXACT = 1'b1;

    localparam int unsigned ST_IDLE = 0;

    typedef struct packed {
        logic [31:0] nxt;
        logic        reject;
    } step_res_t;

    // k + s cannot overflow at 32 bits for any practical SBW/SW.
    function automatic step_res_t step_next(input int unsigned k,
                                            input int unsigned s,
                                            input int unsigned last,
                                            input logic        mode);
        step_res_t   r;
        int unsigned t;
        t        = k + s;
        r.nxt    = k;
        r.reject = 1'b0;
        if (t <= last) begin
            r.nxt = t;
        end else if (mode == MODE_CLAMP) begin
            r.nxt = last;
        end else begin
            r.reject = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/step_dwell_cnt.sv
// Loadable down-counter timing the dwell in the final state.
// Loaded with DWELL-1 on entry; zero means the next enabled cycle leaves.
module step_dwell_cnt #(
    parameter int unsigned DWELL = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CNTW = (DWELL < 2) ? 1 : $clog2(DWELL + 1);

    logic [CNTW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CNTW'(DWELL - 1);
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/step_fsm.sv
// Step-advance sequencer: walks states 0..NST-1 by s, dwells in the last
// state, then returns to idle with a done pulse and a pass-counter increment.
module step_fsm
    import step_fsm_pkg::*;
#(
    parameter int unsigned SW    = 2,
    parameter int unsigned NST   = 4,
    parameter int unsigned SBW   = $clog2(NST),
    parameter int unsigned DWELL = 1,
    parameter int unsigned CW    = 8
) (
    input  logic           clk,
    input  logic           res,
    input  logic           en,
    input  logic           abort,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    output logic [SBW-1:0] state,
    output logic           busy,
    output logic           done,
    output logic           overshoot,
    output logic [CW-1:0]  passes
);

    localparam int unsigned    LAST   = NST - 1;
    localparam logic [SBW-1:0] LAST_S = SBW'(LAST);
    localparam logic [SBW-1:0] IDLE_S = SBW'(ST_IDLE);

    logic [SBW-1:0] r_state;
    logic           r_done;
    logic           r_over;
    logic [CW-1:0]  r_passes;

    step_res_t      w_step;
    logic [SBW-1:0] w_next;
    logic           w_at_last;
    logic           w_illegal;
    logic           w_dwell_zero;
    logic           w_run;
    logic           w_enter_last;

    assign w_step    = step_next(32'(r_state), 32'(s), LAST, mode);
    assign w_next    = SBW'(w_step.nxt);
    assign w_at_last = (r_state == LAST_S);
    // Only reachable when NST is not a power of two and the register is corrupted.
    assign w_illegal = (r_state > LAST_S);
    assign w_run     = en && !res && !abort;

    assign w_enter_last = w_run && !w_at_last && !w_illegal && (w_next == LAST_S);

    step_dwell_cnt #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk (clk),
        .clr (res || abort),
        .load(w_enter_last),
        .dec (w_run && w_at_last),
        .zero(w_dwell_zero)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= IDLE_S;
            r_done   <= 1'b0;
            r_over   <= 1'b0;
            r_passes <= '0;
        end else if (abort) begin
            r_state <= IDLE_S;
            r_done  <= 1'b0;
            r_over  <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
            r_over <= 1'b0;
        end else if (w_illegal) begin
            r_state <= IDLE_S;
            r_done  <= 1'b0;
            r_over  <= 1'b0;
        end else if (w_at_last) begin
            r_over <= 1'b0;
            if (w_dwell_zero) begin
                r_state  <= IDLE_S;
                r_done   <= 1'b1;
                r_passes <= r_passes + CW'(1);
            end else begin
                r_done <= 1'b0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_over  <= w_step.reject;
        end
    end

    assign state     = r_state;
    assign busy      = (r_state != IDLE_S);
    assign done      = r_done;
    assign overshoot = r_over;
    assign passes    = r_passes;

endmodule

// File: doc/step_fsm.md
Name: step_fsm

Overview:
- Parametrised step-advance state machine: walks states 0..NST-1 by a multi-bit step input.
- Dwells a programmable number of cycles in the final state, then returns to idle and counts completed passes.
- Successor to the fixed 4-state, 2-bit-input sequencer.
- Adds selectable clamp/exact step modes, enable, abort, dwell timing and status pulses.
- Used as a control sequencer inside the lab system designs.

Parameters:
- SW, 2, width of step input s.
- NST, 4, number of states; must be >= 2. LAST = NST-1.
- SBW, $clog2(NST), width of the state output.
- DWELL, 1, cycles spent in LAST before returning to 0; must be >= 1.
- CW, 8, width of the pass counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- res  input  1  reset, synchronous, active-high.
- en  input  1  advance enable; 0 freezes all state, the dwell counter and the pass counter.
- abort  input  1  synchronous return to state 0.
- mode  input  1  0 = clamp mode, 1 = exact mode.
- s  input  SW  step amount; 0 = hold.
- state  output  SBW  current state, registered.
- busy  output  1  high when state != 0; combinational from state.
- done  output  1  one-cycle pulse on the cycle state first reads 0 after LAST.
- overshoot  output  1  one-cycle pulse after a step is rejected in exact mode.
- passes  output  CW  completed-pass counter; wraps modulo 2^CW.

Behaviour:
- Reset, sampled at posedge with res=1:
  - state=0, dwell counter=0, passes=0, done=0, overshoot=0.
  - res overrides abort and en.
- Priority each posedge: res > abort > en.
- abort=1 (res=0):
  - state goes to 0 regardless of en.
  - dwell counter cleared; done=0, overshoot=0; passes unchanged.
- en=0 (no res, no abort):
  - state, dwell counter and passes hold.
  - done and overshoot go to 0, so pulses never stretch.
- en=1, state k < LAST:
  - s==0: hold k.
  - Sum t = k + s, computed at SBW+SW+1 bits so it never overflows.
  - Clamp mode: next = min(t, LAST).
  - Exact mode, t <= LAST: next = t.
  - Exact mode, t > LAST: hold k and set overshoot=1 for the next cycle.
  - Any transition into LAST loads the dwell counter with DWELL-1.
- en=1, state == LAST:
  - s and mode are ignored.
  - Dwell counter != 0: decrement it and hold LAST.
  - Dwell counter == 0: next state=0, done=1 for the next cycle, passes increments.
  - passes wraps from 2^CW-1 to 0.
- Dwell timing: with DWELL=D, state reads LAST for exactly D enabled cycles, measured from entry.
- done is registered. It is high in exactly the one cycle where state==0 following LAST, and low otherwise.
- overshoot is registered. It is high for one cycle only, and only in exact mode.
- A mode change takes effect on the same edge it is sampled.
- State encoding is plain binary. Values >= NST are unreachable.
  - If NST is not a power of 2 and the state register is somehow illegal, next state is 0, with no done and no passes increment.
- Reset mid-dwell or mid-walk returns to 0 on that edge, with no done pulse.

Decomposition:
- Package step_fsm_pkg holds:
  - MODE_CLAMP=1'b0, MODE_EXACT=1'b1.
  - ST_IDLE=0.
  - A function computing clamp/exact next-state and the reject flag, given k, s, LAST and mode.
- One sub-module is natural: step_dwell_cnt.
  - Loadable down-counter with ports load, dec, zero and a DWELL parameter.
  - Width $clog2(DWELL+1).
- Pass counter and pulse registers stay in the top module.

Test Plan:
- Defaults (NST=4, SW=2, DWELL=1, CW=8) unless stated.
- Reset: res=1 for 2 cycles with en=1, s=3 -> state=0, busy=0, done=0, overshoot=0, passes=0. Release res -> first advance occurs on the next edge.
- Clamp walk: mode=0, en=1, s=1 then s=3 -> state 0→1→3. Next cycle state=0, done=1 for one cycle, passes=1, busy drops with state.
- Exact reject: mode=1, from state 2 apply s=3 -> state stays 2, overshoot=1 for one cycle. Then s=1 -> state 3, then 0 with done=1.
- Dwell and enable: build with DWELL=3 and enter LAST -> state=3 for 3 cycles then 0. Drop en for 1 cycle mid-dwell -> state=3 for 4 cycles total, and done still lasts exactly one cycle.
- Precedence: in state 2 assert abort with en=1, s=1 -> state=0, done=0, passes unchanged. Assert res and abort together after 5 passes -> passes=0.
- Wrap: build with CW=2 and complete 5 passes -> passes sequence 1,2,3,0,1. A done pulse accompanies each pass.
